// File: rtl/tmon_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tmon_pkg                                                  |
// | Purpose  : Shared types for the temperature-monitor slave: command   |
// |            opcodes, per-channel status codes and controller states.  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package tmon_pkg;

  // Command opcodes; encodings 8..15 all behave as NOOP.
  typedef enum logic [3:0] {
    OP_CLEAR      = 4'd0,
    OP_SET_PERIOD = 4'd1,
    OP_SET_HI     = 4'd2,
    OP_SET_LO     = 4'd3,
    OP_RD_MAX     = 4'd4,
    OP_RD_MIN     = 4'd5,
    OP_RD_AGE     = 4'd6,
    OP_RD_AVG     = 4'd7,
    OP_NOOP       = 4'd8
  } tmon_op_t;

  // Per-channel threshold status.
  typedef enum logic [1:0] {
    ST_OK   = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } tmon_status_t;

  // Command controller states.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } tmon_state_t;

endpackage
`default_nettype wire

// File: rtl/tmon_chan_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tmon_chan_buf                                             |
// | Purpose  : One channel's sample history: ring buffer, fill count,    |
// |            running sum over the window and max/min since clear.      |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tmon_chan_buf
  import tmon_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sample,
  input  logic                   clear,
  input  logic [DW-1:0]          din,
  input  logic [$clog2(DEPTH)-1:0] age,
  output logic [$clog2(DEPTH):0] count,
  output logic [DW-1:0]          max_val,
  output logic [DW-1:0]          min_val,
  output logic [DW-1:0]          age_data,
  output logic [DW-1:0]          avg
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);

  logic [DW-1:0]    ring [DEPTH];
  logic [AW-1:0]    wptr;
  logic [DW+AW-1:0] sum;
  logic [DW+AW-1:0] evict;
  logic             full;
  logic             take;

  // Clear wins over a coincident sample, which is then dropped.
  assign take     = sample && !clear;
  assign full     = (count == FULL_CNT);
  assign evict    = full ? {{AW{1'b0}}, ring[wptr]} : '0;
  assign age_data = ring[wptr - PTR_ONE - age];
  assign avg      = sum[DW+AW-1:AW];

  // Ring storage carries no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (take) ring[wptr] <= din;
  end

  // Pointer, fill count, window sum and extremes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr    <= '0;
      count   <= '0;
      sum     <= '0;
      max_val <= '0;
      min_val <= '0;
    end else if (clear) begin
      wptr    <= '0;
      count   <= '0;
      sum     <= '0;
      max_val <= '0;
      min_val <= '0;
    end else if (sample) begin
      wptr <= wptr + PTR_ONE;
      if (!full) count <= count + CNT_ONE;
      sum <= sum + {{AW{1'b0}}, din} - evict;
      if (count == '0 || din > max_val) max_val <= din;
      if (count == '0 || din < min_val) min_val <= din;
    end
  end

endmodule
`default_nettype wire

// File: rtl/tmon_multi_slave.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tmon_multi_slave                                          |
// | Purpose  : Multi-channel temperature monitor with a command/response |
// |            slave port, periodic sampling into per-channel history    |
// |            buffers and registered HIGH/LOW threshold status.         |
// | Options  : TMON_HYST_EN enables threshold hysteresis of HYST LSBs.   |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tmon_multi_slave
  import tmon_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int HYST  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic [NCH*DW-1:0] temp,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [3:0]        cmd_chan,
  input  logic [7:0]        cmd_opnd,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DW-1:0]     rsp_data,
  output logic              rsp_err,
  output logic [NCH*2-1:0]  status
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
`ifdef TMON_HYST_EN
  localparam bit HYST_ON = 1'b1;
`else
  localparam bit HYST_ON = 1'b0;
`endif
  // A zero hysteresis band reduces the status logic to plain compares.
  localparam logic [DW-1:0] HYST_V = HYST_ON ? DW'(HYST) : '0;

  tmon_state_t state, state_nx;
  tmon_op_t    op_r;
  logic [3:0]  chan_r;
  logic [7:0]  opnd_r;
  logic [7:0]  period, tick_cnt;
  logic [DW-1:0] hi_r [NCH];
  logic [DW-1:0] lo_r [NCH];
  logic        accept, exec, sample, chan_bad;

  logic [NCH*CW-1:0] ch_cnt_v;
  logic [NCH*DW-1:0] ch_max_v, ch_min_v, ch_age_v, ch_avg_v;

  logic [CW-1:0] sel_cnt;
  logic [DW-1:0] sel_max, sel_min, sel_age, sel_avg;
  logic [DW-1:0] data_nx;
  logic          err_nx;

  // State register; asynchronous reset aborts any command in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_nx  = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    exec      = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nx = S_EXEC;
      end
      S_EXEC: begin
        exec     = 1'b1;
        state_nx = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign accept   = cmd_valid && cmd_ready;
  assign chan_bad = ({1'b0, chan_r} >= 5'(NCH));
  // Sample interval is period+1 ticks; period 0 samples every tick.
  assign sample   = tick && (tick_cnt >= period);

  // Capture the command at acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_r   <= OP_NOOP;
      chan_r <= '0;
      opnd_r <= '0;
    end else if (accept) begin
      op_r   <= tmon_op_t'(cmd_op);
      chan_r <= cmd_chan;
      opnd_r <= cmd_opnd;
    end
  end

  // Tick divider.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     tick_cnt <= '0;
    else if (tick) tick_cnt <= sample ? 8'd0 : tick_cnt + 8'd1;
  end

  // Configuration writes, performed in the EXEC cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period <= '0;
      for (int c = 0; c < NCH; c++) begin
        hi_r[c] <= '1;
        lo_r[c] <= '0;
      end
    end else if (exec) begin
      if (op_r == OP_SET_PERIOD) period <= opnd_r;
      for (int c = 0; c < NCH; c++) begin
        if (chan_r == 4'(c)) begin
          if (op_r == OP_SET_HI) hi_r[c] <= DW'(opnd_r);
          if (op_r == OP_SET_LO) lo_r[c] <= DW'(opnd_r);
        end
      end
    end
  end

  // Per-channel history buffers and threshold status.
  for (genvar c = 0; c < NCH; c++) begin : g_chan
    logic            clr;
    logic [DW-1:0]   t;
    logic [DW:0]     hi_d, lo_s;
    logic [DW-1:0]   hi_m, lo_p;
    tmon_status_t    st_q, st_nx;

    assign clr  = exec && (op_r == OP_CLEAR) && (chan_r == 4'(c));
    assign t    = temp[c*DW +: DW];

    tmon_chan_buf #(.DW(DW), .DEPTH(DEPTH)) u_buf (
      .clk      (clk),
      .reset    (reset),
      .sample   (sample),
      .clear    (clr),
      .din      (t),
      .age      (opnd_r[AW-1:0]),
      .count    (ch_cnt_v[c*CW +: CW]),
      .max_val  (ch_max_v[c*DW +: DW]),
      .min_val  (ch_min_v[c*DW +: DW]),
      .age_data (ch_age_v[c*DW +: DW]),
      .avg      (ch_avg_v[c*DW +: DW])
    );

    // Saturating release points of the hysteresis band.
    assign hi_d = {1'b0, hi_r[c]} - {1'b0, HYST_V};
    assign hi_m = hi_d[DW] ? '0 : hi_d[DW-1:0];
    assign lo_s = {1'b0, lo_r[c]} + {1'b0, HYST_V};
    assign lo_p = lo_s[DW] ? '1 : lo_s[DW-1:0];

    // Status classification against the live temperature.
    always_comb begin
      st_nx = ST_OK;
      if (t > hi_r[c])                      st_nx = ST_HIGH;
      else if (st_q == ST_HIGH && t > hi_m) st_nx = ST_HIGH;
      else if (t < lo_r[c])                 st_nx = ST_LOW;
      else if (st_q == ST_LOW && t < lo_p)  st_nx = ST_LOW;
    end

    // Status register, updated every clock.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) st_q <= ST_OK;
      else       st_q <= st_nx;
    end

    assign status[2*c +: 2] = st_q;
  end

  // Response computation from pre-sample buffer state.
  always_comb begin
    sel_cnt = '0;
    sel_max = '0;
    sel_min = '0;
    sel_age = '0;
    sel_avg = '0;
    data_nx = '0;
    err_nx  = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (chan_r == 4'(c)) begin
        sel_cnt = ch_cnt_v[c*CW +: CW];
        sel_max = ch_max_v[c*DW +: DW];
        sel_min = ch_min_v[c*DW +: DW];
        sel_age = ch_age_v[c*DW +: DW];
        sel_avg = ch_avg_v[c*DW +: DW];
      end
    end
    case (op_r)
      OP_CLEAR, OP_SET_HI, OP_SET_LO: err_nx = chan_bad;
      OP_RD_MAX: begin
        if (chan_bad || sel_cnt == '0) err_nx = 1'b1;
        else                           data_nx = sel_max;
      end
      OP_RD_MIN: begin
        if (chan_bad || sel_cnt == '0) err_nx = 1'b1;
        else                           data_nx = sel_min;
      end
      OP_RD_AGE: begin
        if (chan_bad || {1'b0, opnd_r} >= 9'(sel_cnt)) err_nx = 1'b1;
        else                                           data_nx = sel_age;
      end
      OP_RD_AVG: begin
        if (chan_bad || sel_cnt != FULL_CNT) err_nx = 1'b1;
        else                                 data_nx = sel_avg;
      end
      default: ;
    endcase
  end

  // Response register, loaded at the end of EXEC and held through RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else if (exec) begin
      rsp_data <= data_nx;
      rsp_err  <= err_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tmon_multi_slave.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_tmon_multi_slave                                       |
// | Purpose  : Directed, table-driven bench for tmon_multi_slave.        |
// | Options  : honours TMON_HYST_EN for the status expectations.         |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_tmon_multi_slave;
  import tmon_pkg::*;

  localparam int NCH = 4;
  localparam int DW = 8;
  localparam int DEPTH = 16;
`ifdef TMON_HYST_EN
  localparam bit HYST_ON = 1'b1;
`else
  localparam bit HYST_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              tick;
  logic [NCH*DW-1:0] temp;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_op;
  logic [3:0]        cmd_chan;
  logic [7:0]        cmd_opnd;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DW-1:0]     rsp_data;
  logic              rsp_err;
  logic [NCH*2-1:0]  status;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tmon_multi_slave #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH), .HYST(2)) dut (
    .clk(clk), .reset(reset), .tick(tick), .temp(temp),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_chan(cmd_chan), .cmd_opnd(cmd_opnd), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .status(status)
  );

  typedef struct {
    logic [3:0] op;
    logic [3:0] ch;
    logic [7:0] opnd;
    logic [7:0] d;
    logic       e;
  } vec_t;
  vec_t tbl [21];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_temp(input int c, input logic [DW-1:0] v);
    temp[c*DW +: DW] = v;
  endtask

  function automatic logic [NCH*2-1:0] stv(input int c, input logic [1:0] s);
    logic [NCH*2-1:0] r;
    r = '0;
    r[2*c +: 2] = s;
    return r;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  // Accept a command, optionally tick during EXEC, and wait for rsp_valid.
  task automatic issue(input logic [3:0] op, input logic [3:0] ch,
                       input logic [7:0] opnd, input bit exec_tick);
    cmd_op = op; cmd_chan = ch; cmd_opnd = opnd; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    chk("exec_rsp_valid", int'(rsp_valid), 0);
    tick = exec_tick;
    step();
    tick = 1'b0;
    for (int k = 0; k < 8 && !rsp_valid; k++) step();
    chk("resp_latency", int'(rsp_valid), 1);
  endtask

  task automatic complete();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic send(input logic [3:0] op, input logic [3:0] ch,
                      input logic [7:0] opnd, input bit exec_tick,
                      output logic [7:0] d, output logic e);
    issue(op, ch, opnd, exec_tick);
    d = rsp_data;
    e = rsp_err;
    complete();
  endtask

  task automatic send_chk(input string nm, input logic [3:0] op, input logic [3:0] ch,
                          input logic [7:0] opnd, input bit exec_tick,
                          input logic [7:0] ed, input logic ee);
    logic [7:0] d;
    logic       e;
    send(op, ch, opnd, exec_tick, d, e);
    chk({nm, "_data"}, int'(d), int'(ed));
    chk({nm, "_err"}, int'(e), int'(ee));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; tick = 1'b0; temp = '0; cmd_valid = 1'b0;
    cmd_op = '0; cmd_chan = '0; cmd_opnd = '0; rsp_ready = 1'b0;

    tbl[0]  = '{OP_RD_AVG,     4'd0,  8'd0,  8'd9,   1'b0};
    tbl[1]  = '{OP_RD_AGE,     4'd0,  8'd15, 8'd2,   1'b0};
    tbl[2]  = '{OP_RD_MIN,     4'd0,  8'd0,  8'd1,   1'b0};
    tbl[3]  = '{OP_RD_MAX,     4'd0,  8'd0,  8'd17,  1'b0};
    tbl[4]  = '{OP_RD_AGE,     4'd0,  8'd0,  8'd17,  1'b0};
    tbl[5]  = '{OP_RD_AGE,     4'd0,  8'd16, 8'd0,   1'b1};
    tbl[6]  = '{OP_RD_MAX,     4'd1,  8'd0,  8'd199, 1'b0};
    tbl[7]  = '{OP_RD_MIN,     4'd1,  8'd0,  8'd183, 1'b0};
    tbl[8]  = '{OP_RD_AVG,     4'd1,  8'd0,  8'd190, 1'b0};
    tbl[9]  = '{OP_RD_AGE,     4'd1,  8'd15, 8'd198, 1'b0};
    tbl[10] = '{OP_RD_MAX,     4'd3,  8'd0,  8'd34,  1'b0};
    tbl[11] = '{OP_RD_MIN,     4'd3,  8'd0,  8'd2,   1'b0};
    tbl[12] = '{OP_RD_MAX,     4'd4,  8'd0,  8'd0,   1'b1};
    tbl[13] = '{4'd9,          4'd15, 8'd7,  8'd0,   1'b0};
    tbl[14] = '{OP_CLEAR,      4'd5,  8'd0,  8'd0,   1'b1};
    tbl[15] = '{OP_CLEAR,      4'd2,  8'd0,  8'd0,   1'b0};
    tbl[16] = '{OP_RD_MAX,     4'd2,  8'd0,  8'd0,   1'b1};
    tbl[17] = '{OP_RD_AGE,     4'd2,  8'd0,  8'd0,   1'b1};
    tbl[18] = '{OP_RD_AVG,     4'd0,  8'd0,  8'd9,   1'b0};
    tbl[19] = '{OP_SET_PERIOD, 4'd15, 8'd0,  8'd0,   1'b0};
    tbl[20] = '{OP_SET_LO,     4'd4,  8'd9,  8'd0,   1'b1};

    // Reset state.
    do_reset();
    chk("rst_cmd_ready", int'(cmd_ready), 1);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rsp_data", int'(rsp_data), 0);
    chk("rst_rsp_err", int'(rsp_err), 0);
    chk("rst_status", int'(status), 0);

    // Single sample, read-vs-sample ordering, and clear dropping a sample.
    set_temp(0, 8'd20);
    pulse_tick();
    send_chk("age0_first", OP_RD_AGE, 4'd0, 8'd0, 1'b0, 8'd20, 1'b0);
    send_chk("avg_partial", OP_RD_AVG, 4'd0, 8'd0, 1'b0, 8'd0, 1'b1);
    set_temp(0, 8'd77);
    send_chk("age_presample", OP_RD_AGE, 4'd0, 8'd0, 1'b1, 8'd20, 1'b0);
    send_chk("age_postsample", OP_RD_AGE, 4'd0, 8'd0, 1'b0, 8'd77, 1'b0);
    send_chk("age_one", OP_RD_AGE, 4'd0, 8'd1, 1'b0, 8'd20, 1'b0);
    set_temp(0, 8'd88);
    set_temp(1, 8'd44);
    send_chk("clear_tick", OP_CLEAR, 4'd0, 8'd0, 1'b1, 8'd0, 1'b0);
    send_chk("max_cleared", OP_RD_MAX, 4'd0, 8'd0, 1'b0, 8'd0, 1'b1);
    send_chk("ch1_sampled", OP_RD_AGE, 4'd1, 8'd0, 1'b0, 8'd44, 1'b0);
    send_chk("ch1_min", OP_RD_MIN, 4'd1, 8'd0, 1'b0, 8'd0, 1'b0);

    // Sample period 2: one sample every third tick.
    do_reset();
    send_chk("set_period", OP_SET_PERIOD, 4'd0, 8'd2, 1'b0, 8'd0, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      set_temp(0, 8'(i));
      pulse_tick();
    end
    send_chk("per_age0", OP_RD_AGE, 4'd0, 8'd0, 1'b0, 8'd6, 1'b0);
    send_chk("per_age1", OP_RD_AGE, 4'd0, 8'd1, 1'b0, 8'd3, 1'b0);
    send_chk("per_age2", OP_RD_AGE, 4'd0, 8'd2, 1'b0, 8'd0, 1'b1);

    // Seventeen samples on every channel, then the vector table.
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      set_temp(0, 8'(i));
      set_temp(1, 8'(200 - i));
      set_temp(2, 8'(i));
      set_temp(3, 8'(2 * i));
      pulse_tick();
    end
    for (int v = 0; v < 21; v++) begin
      send_chk($sformatf("tbl%0d", v), tbl[v].op, tbl[v].ch, tbl[v].opnd, 1'b0,
               tbl[v].d, tbl[v].e);
    end

    // Response held while rsp_ready is low.
    issue(OP_RD_MAX, 4'd4, 8'd0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      chk("hold_valid", int'(rsp_valid), 1);
      chk("hold_err", int'(rsp_err), 1);
      chk("hold_data", int'(rsp_data), 0);
      chk("hold_cmd_ready", int'(cmd_ready), 0);
      step();
    end
    complete();
    chk("hold_done_valid", int'(rsp_valid), 0);
    chk("hold_done_ready", int'(cmd_ready), 1);

    // Threshold status.
    temp = '0;
    send_chk("set_hi", OP_SET_HI, 4'd1, 8'd50, 1'b0, 8'd0, 1'b0);
    set_temp(1, 8'd50); step();
    chk("st_at_hi", int'(status), int'(stv(1, ST_OK)));
    set_temp(1, 8'd51); step();
    chk("st_high", int'(status), int'(stv(1, ST_HIGH)));
    set_temp(1, 8'd49); step();
    chk("st_hi_49", int'(status), int'(stv(1, HYST_ON ? ST_HIGH : ST_OK)));
    set_temp(1, 8'd48); step();
    chk("st_hi_48", int'(status), int'(stv(1, ST_OK)));
    send_chk("set_lo", OP_SET_LO, 4'd2, 8'd30, 1'b0, 8'd0, 1'b0);
    set_temp(2, 8'd29); step();
    chk("st_low", int'(status), int'(stv(2, ST_LOW)));
    set_temp(2, 8'd31); step();
    chk("st_lo_31", int'(status), int'(stv(2, HYST_ON ? ST_LOW : ST_OK)));
    set_temp(2, 8'd32); step();
    chk("st_lo_32", int'(status), int'(stv(2, ST_OK)));

    // Reset during EXEC aborts the command.
    set_temp(1, 8'd51); step();
    chk("st_pre_rst", int'(status), int'(stv(1, ST_HIGH)));
    cmd_op = OP_RD_MAX; cmd_chan = 4'd0; cmd_opnd = 8'd0; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    chk("abort_in_exec", int'(cmd_ready), 0);
    reset = 1'b1;
    #2;
    chk("abort_async_ready", int'(cmd_ready), 1);
    step();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("abort_rsp_valid", int'(rsp_valid), 0);
    end
    chk("abort_cmd_ready", int'(cmd_ready), 1);
    chk("abort_status", int'(status), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
